// File: rtl/wb_initiator_bridge_if.sv
// Command/response and Wishbone master signal bundle for wb_initiator_bridge.
// wbm_err_i exists only when WB_INITIATOR_BUS_ERR_EN is defined.
interface wb_initiator_bridge_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_adr_i;
   logic [31:0] req_dat_i;
   logic [3:0]  req_sel_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;
`ifdef WB_INITIATOR_BUS_ERR_EN
   logic        wbm_err_i;
`endif

   // Bridge side.
   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
      input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
`ifdef WB_INITIATOR_BUS_ERR_EN
      input  wbm_err_i,
`endif
      output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

   // Requester plus Wishbone slave side.
   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i,
      output rsp_ready_i, wbm_dat_i, wbm_ack_i,
`ifdef WB_INITIATOR_BUS_ERR_EN
      output wbm_err_i,
`endif
      input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );
endinterface

// File: rtl/wb_initiator_bridge.sv
// Single-outstanding Wishbone classic initiator with a bus-timeout watchdog.
// Optional slave error input enabled by WB_INITIATOR_BUS_ERR_EN.
module wb_initiator_bridge #(
   parameter int          TIMEOUT  = 16,
   parameter int          TW       = 8,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   wb_initiator_bridge_if.master bus,
   output logic        busy_o,
   output logic [1:0]  dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; valid holds its payload until then, ready may change freely.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          cyc_q, cyc_d;
   logic          stb_q, stb_d;
   logic          we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   adr_q, adr_d;
   logic [31:0]   wdat_q, wdat_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_dat_q, rsp_dat_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          bus_err;
   logic          timeout_hit;

`ifdef WB_INITIATOR_BUS_ERR_EN
   assign bus_err = bus.wbm_err_i;
`else
   assign bus_err = 1'b0;
`endif

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      stb_d       = stb_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_err_d   = rsp_err_q;
      rsp_dat_d   = rsp_dat_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid_i) begin
               state_d = S_BUS;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = bus.req_we_i;
               sel_d   = bus.req_sel_i;
               adr_d   = bus.req_adr_i;
               wdat_d  = bus.req_dat_i;
               cnt_d   = '0;
            end
         end
         S_BUS: begin
            // Ack beats error beats timeout when they coincide.
            if (bus.wbm_ack_i) begin
               state_d     = S_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? 32'h0 : bus.wbm_dat_i;
            end else if (bus_err || timeout_hit) begin
               state_d     = S_RESP;
               cyc_d       = 1'b0;
               stb_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = ERR_DATA;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_RESP: begin
            if (bus.rsp_ready_i) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= S_IDLE;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         wdat_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_dat_q   <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         stb_q       <= stb_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_dat_q   <= rsp_dat_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready_o = (state_q == S_IDLE);
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_err_o   = rsp_err_q;
   assign bus.rsp_dat_o   = rsp_dat_q;
   assign bus.wbm_cyc_o   = cyc_q;
   assign bus.wbm_stb_o   = stb_q;
   assign bus.wbm_we_o    = we_q;
   assign bus.wbm_sel_o   = sel_q;
   assign bus.wbm_adr_o   = adr_q;
   assign bus.wbm_dat_o   = wdat_q;
   assign busy_o          = busy_q;
   assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_wb_initiator_bridge.sv
// Directed bench for wb_initiator_bridge (TIMEOUT=16); bus-error cases need WB_INITIATOR_BUS_ERR_EN.
module tb_wb_initiator_bridge;

   logic       clk;
   logic       rst_n;
   logic       busy;
   logic [1:0] dbg_state;
   int         checks;
   int         failures;

   wb_initiator_bridge_if bus ();

   wb_initiator_bridge #(.TIMEOUT(16), .TW(8), .ERR_DATA(32'hDEADBEEF)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n_i  (rst_n),
      .bus         (bus),
      .busy_o      (busy),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entered and left at a falling edge; valid is dropped after acceptance.
   task automatic send_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
      int n;
      n = 0;
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_adr_i   = adr;
      bus.req_dat_i   = dat;
      bus.req_sel_i   = sel;
      while (bus.req_ready_o !== 1'b1 && n < 50) begin
         @(posedge clk); @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         failures++;
         $display("FAIL send_req_wait: req_ready_o=%b required 1 within 50 cycles", bus.req_ready_o);
      end
      @(posedge clk); @(negedge clk);
      bus.req_valid_i = 1'b0;
   endtask

   // Slave model: ack (and optionally err) at a given stb cycle index; -1 means never.
   task automatic run_bus(input int ack_at, input int err_at, input logic [31:0] rdat,
                          output int stb_cycles);
      int k;
      k = 0;
      while (bus.wbm_stb_o === 1'b1 && k < 100) begin
         bus.wbm_dat_i = 32'h5A5A_0F0F;
         if (k == ack_at) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = rdat;
         end
`ifdef WB_INITIATOR_BUS_ERR_EN
         if (k == err_at) bus.wbm_err_i = 1'b1;
`endif
         @(posedge clk); @(negedge clk);
         bus.wbm_ack_i = 1'b0;
`ifdef WB_INITIATOR_BUS_ERR_EN
         bus.wbm_err_i = 1'b0;
`endif
         k++;
      end
      stb_cycles = k;
      checks++;
      if (k >= 100 || err_at < -1) begin
         failures++;
         $display("FAIL run_bus_bound: stb still high after %0d cycles", k);
      end
   endtask

   task automatic consume_rsp();
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.rsp_valid_o, bus.rsp_err_o, busy} !== 6'b0 ||
          bus.wbm_sel_o !== 4'h0 || bus.wbm_adr_o !== 32'h0 || bus.wbm_dat_o !== 32'h0 ||
          bus.rsp_dat_o !== 32'h0 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_outputs: cyc=%b stb=%b rsp_valid=%b rsp_dat=%h busy=%b state=%0d required all 0",
                  bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.rsp_dat_o, busy, dbg_state);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: req_ready_o=%b required 1", bus.req_ready_o);
      end
   endtask

   task automatic test_write();
      int sc;
      send_req(1'b1, 32'h0001_0004, 32'hA5A5_1234, 4'hF);
      checks++;
      if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== 1'b1 ||
          bus.wbm_adr_o !== 32'h0001_0004 || bus.wbm_dat_o !== 32'hA5A5_1234 || bus.wbm_sel_o !== 4'hF) begin
         failures++;
         $display("FAIL write_bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h required 1 1 1 00010004 a5a51234 f",
                  bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o);
      end
      checks++;
      if (bus.req_ready_o !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL write_busy: req_ready=%b busy=%b required 0 1", bus.req_ready_o, busy);
      end
      run_bus(1, -1, 32'h5555_AAAA, sc);
      checks++;
      if (sc !== 2) begin
         failures++;
         $display("FAIL write_stb_cycles: got %0d required 2", sc);
      end
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 || bus.rsp_dat_o !== 32'h0 || bus.wbm_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL write_rsp: valid=%b err=%b dat=%h cyc=%b required 1 0 00000000 0",
                  bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o, bus.wbm_cyc_o);
      end
      consume_rsp();
      checks++;
      if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 || busy !== 1'b0 ||
          bus.wbm_adr_o !== 32'h0001_0004 || bus.wbm_we_o !== 1'b1) begin
         failures++;
         $display("FAIL write_done: rsp_valid=%b req_ready=%b busy=%b adr=%h we=%b required 0 1 0 00010004 1",
                  bus.rsp_valid_o, bus.req_ready_o, busy, bus.wbm_adr_o, bus.wbm_we_o);
      end
   endtask

   task automatic test_read();
      int sc;
      send_req(1'b0, 32'h0002_0010, 32'h0, 4'hF);
      run_bus(3, -1, 32'hCAFE_F00D, sc);
      checks++;
      if (sc !== 4 || bus.wbm_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle: stb_cycles=%0d cyc=%b required 4 0", sc, bus.wbm_cyc_o);
      end
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b0 || bus.rsp_dat_o !== 32'hCAFE_F00D) begin
         failures++;
         $display("FAIL read_rsp: valid=%b err=%b dat=%h required 1 0 cafef00d",
                  bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
      end
      consume_rsp();
      checks++;
      if (bus.rsp_dat_o !== 32'hCAFE_F00D || bus.rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL read_hold_dat: dat=%h valid=%b required cafef00d 0", bus.rsp_dat_o, bus.rsp_valid_o);
      end
   endtask

   task automatic test_timeout();
      int sc;
      send_req(1'b0, 32'h0003_0000, 32'h0, 4'h3);
      run_bus(-1, -1, 32'h0, sc);
      checks++;
      if (sc !== 16) begin
         failures++;
         $display("FAIL timeout_stb_cycles: got %0d required 16", sc);
      end
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== 1'b1 || bus.rsp_dat_o !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL timeout_rsp: valid=%b err=%b dat=%h required 1 1 deadbeef",
                  bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o);
      end
      consume_rsp();
      checks++;
      if (bus.rsp_err_o !== 1'b0) begin
         failures++;
         $display("FAIL timeout_err_clear: err=%b required 0", bus.rsp_err_o);
      end
      send_req(1'b0, 32'h0003_0004, 32'h0, 4'hF);
      run_bus(15, -1, 32'h1122_3344, sc);
      checks++;
      if (sc !== 16 || bus.rsp_err_o !== 1'b0 || bus.rsp_dat_o !== 32'h1122_3344 || bus.rsp_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL ack_at_abort: stb_cycles=%0d err=%b dat=%h valid=%b required 16 0 11223344 1",
                  sc, bus.rsp_err_o, bus.rsp_dat_o, bus.rsp_valid_o);
      end
      consume_rsp();
   endtask

   task automatic test_backpressure();
      int sc;
      int bad;
      send_req(1'b0, 32'h0004_0008, 32'h0, 4'hF);
      run_bus(0, -1, 32'h7777_1111, sc);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_adr_i   = 32'h0004_000C;
      bus.req_dat_i   = 32'h0BAD_CAFE;
      bus.req_sel_i   = 4'h1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h7777_1111 ||
             bus.req_ready_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0) bad++;
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold: %0d bad cycles required 0 (last valid=%b dat=%h ready=%b cyc=%b)",
                  bad, bus.rsp_valid_o, bus.rsp_dat_o, bus.req_ready_o, bus.wbm_cyc_o);
      end
      consume_rsp();
      checks++;
      if (bus.req_ready_o !== 1'b1 || bus.wbm_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release: req_ready=%b cyc=%b required 1 0", bus.req_ready_o, bus.wbm_cyc_o);
      end
      @(posedge clk); @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++;
      if (bus.wbm_stb_o !== 1'b1 || bus.wbm_adr_o !== 32'h0004_000C || bus.wbm_sel_o !== 4'h1) begin
         failures++;
         $display("FAIL backpressure_next: stb=%b adr=%h sel=%h required 1 0004000c 1",
                  bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_sel_o);
      end
      run_bus(0, -1, 32'h0, sc);
      consume_rsp();
   endtask

   task automatic test_back_to_back();
      send_req(1'b0, 32'h0005_0000, 32'h0, 4'hF);
      bus.wbm_ack_i   = 1'b1;
      bus.wbm_dat_i   = 32'h0BAD_F00D;
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h0BAD_F00D) begin
         failures++;
         $display("FAIL b2b_latency: rsp_valid=%b dat=%h required 1 0badf00d", bus.rsp_valid_o, bus.rsp_dat_o);
      end
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_adr_i   = 32'h0005_0004;
      bus.req_dat_i   = 32'h1357_9BDF;
      bus.req_sel_i   = 4'hC;
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: req_ready=%b rsp_valid=%b required 1 0", bus.req_ready_o, bus.rsp_valid_o);
      end
      @(posedge clk); @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++;
      if (bus.wbm_stb_o !== 1'b1 || bus.wbm_we_o !== 1'b1 || bus.wbm_dat_o !== 32'h1357_9BDF) begin
         failures++;
         $display("FAIL b2b_second: stb=%b we=%b dat=%h required 1 1 13579bdf",
                  bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_dat_o);
      end
      bus.wbm_ack_i = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== 32'h0 || bus.rsp_err_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_second_rsp: valid=%b dat=%h err=%b required 1 0 0",
                  bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_err_o);
      end
      @(posedge clk); @(negedge clk);
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      send_req(1'b1, 32'h0006_0000, 32'hFFFF_0000, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async: cyc=%b stb=%b rsp_valid=%b busy=%b required 0 0 0 0",
                  bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_ready: req_ready=%b required 1", bus.req_ready_o);
      end
      bus.wbm_ack_i = 1'b1;
      repeat (3) @(negedge clk);
      bus.wbm_ack_i = 1'b0;
      checks++;
      if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0 || bus.wbm_cyc_o !== 1'b0) begin
         failures++;
         $display("FAIL spurious_ack: rsp_valid=%b busy=%b state=%0d cyc=%b required 0 0 0 0",
                  bus.rsp_valid_o, busy, dbg_state, bus.wbm_cyc_o);
      end
   endtask

`ifdef WB_INITIATOR_BUS_ERR_EN
   task automatic test_bus_err();
      int sc;
      send_req(1'b0, 32'h0007_0000, 32'h0, 4'hF);
      run_bus(-1, 1, 32'h0, sc);
      checks++;
      if (sc !== 2 || bus.rsp_err_o !== 1'b1 || bus.rsp_dat_o !== 32'hDEADBEEF || bus.rsp_valid_o !== 1'b1) begin
         failures++;
         $display("FAIL bus_err: stb_cycles=%0d err=%b dat=%h valid=%b required 2 1 deadbeef 1",
                  sc, bus.rsp_err_o, bus.rsp_dat_o, bus.rsp_valid_o);
      end
      consume_rsp();
      send_req(1'b0, 32'h0007_0004, 32'h0, 4'hF);
      run_bus(0, 0, 32'h2468_ACE0, sc);
      checks++;
      if (sc !== 1 || bus.rsp_err_o !== 1'b0 || bus.rsp_dat_o !== 32'h2468_ACE0) begin
         failures++;
         $display("FAIL ack_over_err: stb_cycles=%0d err=%b dat=%h required 1 0 2468ace0",
                  sc, bus.rsp_err_o, bus.rsp_dat_o);
      end
      consume_rsp();
   endtask
`endif

   initial begin
      checks          = 0;
      failures        = 0;
      rst_n           = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_we_i    = 1'b0;
      bus.req_adr_i   = 32'h0;
      bus.req_dat_i   = 32'h0;
      bus.req_sel_i   = 4'h0;
      bus.rsp_ready_i = 1'b0;
      bus.wbm_dat_i   = 32'h0;
      bus.wbm_ack_i   = 1'b0;
`ifdef WB_INITIATOR_BUS_ERR_EN
      bus.wbm_err_i   = 1'b0;
`endif
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef WB_INITIATOR_BUS_ERR_EN
      test_bus_err();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_initiator_bridge.md
Name: wb_initiator_bridge

Overview:
- Single-outstanding Wishbone classic initiator that drives the user-project slave bus (`wbs_*` side of the peripheral interconnect).
- Accepts one request at a time from a valid/ready command port (test sequencer, UART command decoder, DMA seed).
- Runs one Wishbone classic cycle per request and returns read data or an error on a valid/ready response port.
- Provides a bus-timeout watchdog so a missing ack never hangs the requester.

Parameters:
- TIMEOUT, 16, cycles in BUS state without ack before abort; 0 disables the watchdog.
- TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TW.
- ERR_DATA, 32'hDEADBEEF, rsp_dat value returned on timeout or bus error.

Ports:
- wb_clk_i  input  1  sole clock, rising edge.
- wb_rst_n_i  input  1  reset, asynchronous assert, active-low.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid&ready.
- req_we_i  input  1  1=write, 0=read.
- req_adr_i  input  32  byte address.
- req_dat_i  input  32  write data.
- req_sel_i  input  4  byte lanes.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumed when valid&ready.
- rsp_dat_o  output  32  read data; 0 for writes; ERR_DATA on error.
- rsp_err_o  output  1  1=timeout/bus error.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte select.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone ack; may be combinational from stb.
- busy_o  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (async, wb_rst_n_i=0):
  - state=IDLE.
  - All wbm_* outputs, rsp_valid_o, rsp_err_o, rsp_dat_o, busy_o and the timeout counter are 0.
  - req_ready_o=1 once reset deasserts.
  - Reset mid-cycle drops cyc/stb immediately and discards the pending request and any response.
- FSM states: IDLE, BUS, RESP. All outputs are registered except req_ready_o, which equals (state==IDLE).
- IDLE:
  - On req_valid_i&req_ready_o, latch we/adr/dat/sel onto wbm_* and set cyc=stb=1.
  - Next state is BUS; clear the counter.
  - wbm_dat_o and wbm_sel_o are driven only from the latched request.
- BUS:
  - cyc, stb, we, adr, sel and dat are held stable.
  - If wbm_ack_i=1:
    - cyc=stb=0 next cycle; rsp_valid_o=1; rsp_err_o=0.
    - rsp_dat_o = wbm_dat_i for reads, 0 for writes.
    - Next state is RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1:
    - Abort: cyc=stb=0; rsp_valid_o=1; rsp_err_o=1; rsp_dat_o=ERR_DATA.
    - Next state is RESP.
  - Else the counter increments. It saturates at all-ones and never wraps.
  - Ack and timeout in the same cycle: ack wins.
- RESP:
  - rsp_* are held until rsp_valid_o&rsp_ready_i.
  - On that handshake: rsp_valid_o=0, rsp_err_o=0, next state is IDLE.
  - rsp_dat_o keeps its last value.
- Latency, with a combinational-ack slave:
  - Request handshake at cycle N; stb high at N+1; rsp_valid_o at N+2.
  - Earliest next request acceptance is N+3 if rsp_ready_i=1 at N+2.
  - Peak throughput is one transaction per 3 cycles.
- wbm_ack_i outside BUS is ignored and causes no state change.
- wbm_we_o/sel/adr/dat keep their last values while cyc=0.

Optional Feature:
- Macro WB_INITIATOR_BUS_ERR_EN.
- Defined:
  - Adds input port wbm_err_i (1 bit).
  - In BUS, wbm_err_i=1 ends the cycle exactly like a timeout (rsp_err_o=1, rsp_dat_o=ERR_DATA).
  - Priority: ack > err > timeout.
- Undefined:
  - No wbm_err_i port.
  - Errors arise only from timeout.

Test Plan:
- Write: req we=1, adr=32'h0001_0004, dat=32'hA5A5_1234, sel=4'hF; slave acks 1 cycle after stb -> wbm_* match the request; one stb pulse; rsp_valid=1, rsp_err=0, rsp_dat=0.
- Read: req we=0, adr=32'h0002_0010; slave acks with dat=32'hCAFE_F00D after 3 wait cycles -> rsp_dat=32'hCAFE_F00D, rsp_err=0; cyc low the cycle after ack.
- Timeout: TIMEOUT=16, slave never acks -> cyc/stb high exactly 16 cycles, then rsp_err=1 and rsp_dat=32'hDEADBEEF; ack at the abort cycle instead -> normal response.
- Backpressure: rsp_ready_i=0 for 5 cycles after a read -> rsp_valid/rsp_dat stable; req_ready_o=0 throughout; a new req is not accepted until after the handshake.
- Reset mid-cycle: assert wb_rst_n_i=0 while stb=1 -> cyc/stb/rsp_valid go 0 asynchronously; after release req_ready_o=1; a spurious ack in IDLE causes no response.
- WB_INITIATOR_BUS_ERR_EN: err_i=1 on the second BUS cycle -> rsp_err=1, rsp_dat=32'hDEADBEEF; ack and err asserted together -> normal response.
